// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline scheduler for the 5-stage MIPS datapath. Owns PC write enable and
// IF/ID write/flush, drives NoOp into Control, inserts load-use bubbles,
// flushes IF/ID on taken beq / j, and freezes the whole pipeline while a
// data-memory access in MEM completes.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
// cycles without dmem_ready_i; the abort sets the sticky DmemErr_o flag.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   IDEX_MemRd_i, IDEX_Rt_i      lw in EX and its destination register
//   IFID_Rs_i, IFID_Rt_i         source registers of the instruction in ID
//   EXMEM_MemRd_i/MemWr_i        lw / sw in MEM (starts a memory access)
//   BrTaken_i, Jump_i            control-flow change resolved in ID
//   dmem_ready_i / dmem_req_o    data memory handshake
//   PCWrite_o, IFID_Write_o      PC and IF/ID write enables
//   IFID_Flush_o                 IF/ID clears to nop
//   NoOp_o                       zeroes ID-stage control signals
//   PipeStall_o                  freezes ID/EX, EX/MEM, MEM/WB
//   StallCnt_o                   saturating count of cycles with PCWrite_o=0
//   DmemErr_o                    sticky timeout flag (0 without DMEM_TIMEOUT_EN)
//   dbg_state_o                  current FSM state (0 = RUN, 1 = WAIT)
//
// Memory handshake: dmem_req_o is a level held from the first cycle a memory
// op sits in MEM until (and including) the cycle dmem_ready_i is seen in WAIT.
// The access completes on the rising edge where req=1 and ready=1; ready is
// ignored in RUN, so every access takes at least two cycles.
module hazard_stall_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRd_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             EXMEM_MemRd_i,
    input  logic             EXMEM_MemWr_i,
    input  logic             BrTaken_i,
    input  logic             Jump_i,
    input  logic             dmem_ready_i,
    output logic             dmem_req_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             NoOp_o,
    output logic             PipeStall_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic             DmemErr_o,
    output logic             dbg_state_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_mem_op;
    logic             w_load_use;
    logic             w_ctl_flow;
    logic             w_timeout;

    assign w_mem_op   = EXMEM_MemRd_i | EXMEM_MemWr_i;
    // $0 is hard-wired zero, so a lw targeting it never creates a dependency.
    assign w_load_use = IDEX_MemRd_i && (IDEX_Rt_i != 5'd0) &&
                        ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));
    assign w_ctl_flow = BrTaken_i | Jump_i;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // The last allowed WAIT cycle without ready aborts the access.
    assign w_timeout = (r_state == ST_WAIT) && !dmem_ready_i &&
                       (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            // Held at zero in RUN so every WAIT starts counting from zero.
            if (r_state == ST_RUN) begin
                r_to_cnt <= '0;
            end else if (!dmem_ready_i) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign DmemErr_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign DmemErr_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        dmem_req_o   = 1'b0;
        PipeStall_o  = 1'b0;
        PCWrite_o    = 1'b1;
        IFID_Write_o = 1'b1;
        IFID_Flush_o = 1'b0;
        NoOp_o       = 1'b0;
        if (!rst_i) begin
            w_state_nxt  = ST_RUN;
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            NoOp_o       = 1'b1;
        end else if ((r_state == ST_RUN && w_mem_op) ||
                     (r_state == ST_WAIT && !dmem_ready_i && !w_timeout)) begin
            // Memory freeze: outranks load-use and flush.
            w_state_nxt  = ST_WAIT;
            dmem_req_o   = 1'b1;
            PipeStall_o  = 1'b1;
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
        end else begin
            // Pipeline advances this edge: plain RUN, the ready cycle, or an
            // aborted access. Req stays high through the ready cycle only.
            w_state_nxt = ST_RUN;
            dmem_req_o  = (r_state == ST_WAIT) && dmem_ready_i;
            if (w_load_use) begin
                // Stall wins over a branch; the branch is seen again next cycle.
                PCWrite_o    = 1'b0;
                IFID_Write_o = 1'b0;
                NoOp_o       = 1'b1;
            end else if (w_ctl_flow) begin
                IFID_Flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!PCWrite_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign StallCnt_o  = r_stall_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. The counter is built 4 bits wide so
// saturation is reachable quickly; TIMEOUT is 8 for the optional abort path.
module tb_hazard_stall_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk_i;
    logic             rst_i;
    logic             IDEX_MemRd_i;
    logic [4:0]       IDEX_Rt_i;
    logic [4:0]       IFID_Rs_i;
    logic [4:0]       IFID_Rt_i;
    logic             EXMEM_MemRd_i;
    logic             EXMEM_MemWr_i;
    logic             BrTaken_i;
    logic             Jump_i;
    logic             dmem_ready_i;
    logic             dmem_req_o;
    logic             PCWrite_o;
    logic             IFID_Write_o;
    logic             IFID_Flush_o;
    logic             NoOp_o;
    logic             PipeStall_o;
    logic [CNT_W-1:0] StallCnt_o;
    logic             DmemErr_o;
    logic             dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .IDEX_MemRd_i  (IDEX_MemRd_i),
        .IDEX_Rt_i     (IDEX_Rt_i),
        .IFID_Rs_i     (IFID_Rs_i),
        .IFID_Rt_i     (IFID_Rt_i),
        .EXMEM_MemRd_i (EXMEM_MemRd_i),
        .EXMEM_MemWr_i (EXMEM_MemWr_i),
        .BrTaken_i     (BrTaken_i),
        .Jump_i        (Jump_i),
        .dmem_ready_i  (dmem_ready_i),
        .dmem_req_o    (dmem_req_o),
        .PCWrite_o     (PCWrite_o),
        .IFID_Write_o  (IFID_Write_o),
        .IFID_Flush_o  (IFID_Flush_o),
        .NoOp_o        (NoOp_o),
        .PipeStall_o   (PipeStall_o),
        .StallCnt_o    (StallCnt_o),
        .DmemErr_o     (DmemErr_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance past the next rising edge; inputs change and outputs are read
    // 1 time unit after the edge, well away from it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        IDEX_MemRd_i  = 1'b0;
        IDEX_Rt_i     = 5'd0;
        IFID_Rs_i     = 5'd0;
        IFID_Rt_i     = 5'd0;
        EXMEM_MemRd_i = 1'b0;
        EXMEM_MemWr_i = 1'b0;
        BrTaken_i     = 1'b0;
        Jump_i        = 1'b0;
        dmem_ready_i  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_i         = 1'b0;
        EXMEM_MemRd_i = 1'b1;
        BrTaken_i     = 1'b1;
        #1;
        n_checks++; if (PCWrite_o !== 1'b0) begin n_fail++; $display("FAIL rst_pcwrite: got %b exp 0", PCWrite_o); end
        n_checks++; if (IFID_Write_o !== 1'b0) begin n_fail++; $display("FAIL rst_ifidwrite: got %b exp 0", IFID_Write_o); end
        n_checks++; if (IFID_Flush_o !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b exp 0", IFID_Flush_o); end
        n_checks++; if (dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", dmem_req_o); end
        n_checks++; if (PipeStall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", PipeStall_o); end
        n_checks++; if (NoOp_o !== 1'b1) begin n_fail++; $display("FAIL rst_noop: got %b exp 1", NoOp_o); end
        tick();
        tick();
        clear_inputs();
        rst_i = 1'b1;
        #1;
        exp_cnt = 0;
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL rst_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
        n_checks++; if (DmemErr_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", DmemErr_o); end
        n_checks++; if (dbg_state_o !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %b exp 0", dbg_state_o); end
        n_checks++; if (PCWrite_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_pcwrite: got %b exp 1", PCWrite_o); end
    endtask

    task automatic test_load_use();
        // lw $2 in EX, ID reads rs=$2
        IDEX_MemRd_i = 1'b1; IDEX_Rt_i = 5'd2; IFID_Rs_i = 5'd2; IFID_Rt_i = 5'd3;
        #1;
        n_checks++; if (PCWrite_o !== 1'b0) begin n_fail++; $display("FAIL lu_rs_pcwrite: got %b exp 0", PCWrite_o); end
        n_checks++; if (IFID_Write_o !== 1'b0) begin n_fail++; $display("FAIL lu_rs_ifidwrite: got %b exp 0", IFID_Write_o); end
        n_checks++; if (NoOp_o !== 1'b1) begin n_fail++; $display("FAIL lu_rs_noop: got %b exp 1", NoOp_o); end
        n_checks++; if (PipeStall_o !== 1'b0) begin n_fail++; $display("FAIL lu_rs_pipestall: got %b exp 0", PipeStall_o); end
        tick();
        exp_cnt++;
        IDEX_MemRd_i = 1'b0;  // bubble now sits in EX
        #1;
        n_checks++; if (PCWrite_o !== 1'b1) begin n_fail++; $display("FAIL lu_after_pcwrite: got %b exp 1", PCWrite_o); end
        n_checks++; if (NoOp_o !== 1'b0) begin n_fail++; $display("FAIL lu_after_noop: got %b exp 0", NoOp_o); end
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL lu_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
        // match through rt
        IDEX_MemRd_i = 1'b1; IDEX_Rt_i = 5'd7; IFID_Rs_i = 5'd1; IFID_Rt_i = 5'd7;
        #1;
        n_checks++; if (NoOp_o !== 1'b1) begin n_fail++; $display("FAIL lu_rt_noop: got %b exp 1", NoOp_o); end
        tick();
        exp_cnt++;
        clear_inputs();
        #1;
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL lu_rt_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
    endtask

    task automatic test_no_hazard();
        // lw $0: never a dependency
        IDEX_MemRd_i = 1'b1; IDEX_Rt_i = 5'd0; IFID_Rs_i = 5'd0; IFID_Rt_i = 5'd0;
        #1;
        n_checks++; if (PCWrite_o !== 1'b1) begin n_fail++; $display("FAIL zero_pcwrite: got %b exp 1", PCWrite_o); end
        n_checks++; if (NoOp_o !== 1'b0) begin n_fail++; $display("FAIL zero_noop: got %b exp 0", NoOp_o); end
        tick();
        // lw $5 with unrelated ID registers
        IDEX_Rt_i = 5'd5; IFID_Rs_i = 5'd4; IFID_Rt_i = 5'd6;
        #1;
        n_checks++; if (PCWrite_o !== 1'b1) begin n_fail++; $display("FAIL nomatch_pcwrite: got %b exp 1", PCWrite_o); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL nohaz_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
    endtask

    task automatic test_mem_freeze();
        int req_cycles;
        int stall_cycles;
        req_cycles = 0;
        stall_cycles = 0;
        EXMEM_MemWr_i = 1'b1;
        // cycle 0 RUN, cycles 1..3 WAIT with ready in cycle 3
        for (int c = 0; c < 4; c++) begin
            dmem_ready_i = (c == 3);
            #1;
            if (dmem_req_o === 1'b1) req_cycles++;
            if (PipeStall_o === 1'b1) stall_cycles++;
            if (c == 0) begin
                n_checks++; if (NoOp_o !== 1'b0) begin n_fail++; $display("FAIL mem_noop: got %b exp 0", NoOp_o); end
                n_checks++; if (PCWrite_o !== 1'b0) begin n_fail++; $display("FAIL mem_pcwrite: got %b exp 0", PCWrite_o); end
            end
            if (c == 3) begin
                n_checks++; if (PCWrite_o !== 1'b1) begin n_fail++; $display("FAIL mem_ready_pcwrite: got %b exp 1", PCWrite_o); end
            end
            tick();
        end
        clear_inputs();
        #1;
        exp_cnt += 3;
        if (dmem_req_o === 1'b1) req_cycles++;
        if (PipeStall_o === 1'b1) stall_cycles++;
        n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL mem_req_cycles: got %0d exp 4", req_cycles); end
        n_checks++; if (stall_cycles != 3) begin n_fail++; $display("FAIL mem_stall_cycles: got %0d exp 3", stall_cycles); end
        n_checks++; if (dbg_state_o !== 1'b0) begin n_fail++; $display("FAIL mem_state: got %b exp 0", dbg_state_o); end
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL mem_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        // lw in MEM, dependent lw in EX / user in ID
        EXMEM_MemRd_i = 1'b1;
        IDEX_MemRd_i = 1'b1; IDEX_Rt_i = 5'd9; IFID_Rs_i = 5'd9;
        #1;
        n_checks++; if (NoOp_o !== 1'b0 || dmem_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_freeze: noop %b req %b exp 0 1", NoOp_o, dmem_req_o); end
        tick();
        dmem_ready_i = 1'b1;
        #1;
        // ready cycle: freeze released, load-use hazard now visible
        n_checks++; if (PipeStall_o !== 1'b0 || dmem_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: stall %b req %b exp 0 1", PipeStall_o, dmem_req_o); end
        n_checks++; if (NoOp_o !== 1'b1 || PCWrite_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_lu: noop %b pcw %b exp 1 0", NoOp_o, PCWrite_o); end
        tick();
        // the lw moved from EX into MEM, bubble in EX
        dmem_ready_i = 1'b0; IDEX_MemRd_i = 1'b0;
        #1;
        n_checks++; if (dmem_req_o !== 1'b1 || PipeStall_o !== 1'b1 || dbg_state_o !== 1'b0) begin n_fail++; $display("FAIL b2b_new_req: req %b stall %b st %b exp 1 1 0", dmem_req_o, PipeStall_o, dbg_state_o); end
        tick();
        dmem_ready_i = 1'b1;
        #1;
        n_checks++; if (PCWrite_o !== 1'b1 || PipeStall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done: pcw %b stall %b exp 1 0", PCWrite_o, PipeStall_o); end
        tick();
        clear_inputs();
        #1;
        exp_cnt += 3;
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
    endtask

    task automatic test_branch_load_use();
        BrTaken_i = 1'b1;
        IDEX_MemRd_i = 1'b1; IDEX_Rt_i = 5'd4; IFID_Rt_i = 5'd4;
        #1;
        n_checks++; if (IFID_Flush_o !== 1'b0 || NoOp_o !== 1'b1) begin n_fail++; $display("FAIL br_lu: flush %b noop %b exp 0 1", IFID_Flush_o, NoOp_o); end
        tick();
        exp_cnt++;
        IDEX_MemRd_i = 1'b0;
        #1;
        n_checks++; if (IFID_Flush_o !== 1'b1 || PCWrite_o !== 1'b1 || IFID_Write_o !== 1'b1 || NoOp_o !== 1'b0) begin
            n_fail++; $display("FAIL br_flush: flush %b pcw %b ifw %b noop %b exp 1 1 1 0", IFID_Flush_o, PCWrite_o, IFID_Write_o, NoOp_o);
        end
        tick();
        clear_inputs();
        Jump_i = 1'b1;
        #1;
        n_checks++; if (IFID_Flush_o !== 1'b1) begin n_fail++; $display("FAIL jump_flush: got %b exp 1", IFID_Flush_o); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL br_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
    endtask

    task automatic test_saturation();
        IDEX_MemRd_i = 1'b1; IDEX_Rt_i = 5'd3; IFID_Rs_i = 5'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_cnt = (exp_cnt + 1 > CNT_MAX) ? CNT_MAX : exp_cnt + 1;
        end
        clear_inputs();
        #1;
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
    endtask

    task automatic test_reset_in_wait();
        EXMEM_MemRd_i = 1'b1;
        tick();
        #1;
        n_checks++; if (dbg_state_o !== 1'b1 || dmem_req_o !== 1'b1) begin n_fail++; $display("FAIL rw_wait: st %b req %b exp 1 1", dbg_state_o, dmem_req_o); end
        rst_i = 1'b0;
        #1;
        n_checks++; if (dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_req_in_rst: got %b exp 0", dmem_req_o); end
        tick();
        rst_i = 1'b1;
        clear_inputs();
        #1;
        exp_cnt = 0;
        n_checks++; if (dbg_state_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_after: st %b req %b exp 0 0", dbg_state_o, dmem_req_o); end
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt) || DmemErr_o !== 1'b0) begin n_fail++; $display("FAIL rw_cnt_err: cnt %0d err %b exp 0 0", StallCnt_o, DmemErr_o); end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int bad_wait;
        bad_wait = 0;
        EXMEM_MemRd_i = 1'b1;
        tick();  // RUN cycle -> WAIT
        for (int w = 1; w <= 8; w++) begin
            #1;
            if (w < 8) begin
                if (dmem_req_o !== 1'b1 || PipeStall_o !== 1'b1) bad_wait++;
            end else begin
                n_checks++; if (dmem_req_o !== 1'b0 || PipeStall_o !== 1'b0 || PCWrite_o !== 1'b1) begin
                    n_fail++; $display("FAIL to_abort: req %b stall %b pcw %b exp 0 0 1", dmem_req_o, PipeStall_o, PCWrite_o);
                end
            end
            tick();
        end
        clear_inputs();
        #1;
        exp_cnt += 8;
        n_checks++; if (bad_wait != 0) begin n_fail++; $display("FAIL to_wait_cycles: %0d bad cycles exp 0", bad_wait); end
        n_checks++; if (DmemErr_o !== 1'b1 || dbg_state_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL to_after: err %b st %b req %b exp 1 0 0", DmemErr_o, dbg_state_o, dmem_req_o);
        end
        n_checks++; if (StallCnt_o !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL to_cnt: got %0d exp %0d", StallCnt_o, exp_cnt); end
    endtask
`else
    task automatic test_no_timeout();
        int dropped;
        dropped = 0;
        EXMEM_MemRd_i = 1'b1;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (dmem_req_o !== 1'b1 || dbg_state_o !== 1'b1) dropped++;
        end
        n_checks++; if (dropped != 0) begin n_fail++; $display("FAIL nto_hold: %0d cycles left WAIT exp 0", dropped); end
        n_checks++; if (DmemErr_o !== 1'b0) begin n_fail++; $display("FAIL nto_err: got %b exp 0", DmemErr_o); end
        dmem_ready_i = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (dbg_state_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL nto_release: st %b req %b exp 0 0", dbg_state_o, dmem_req_o); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        rst_i = 1'b0;
        tick();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_freeze();
        test_back_to_back();
        test_branch_load_use();
        test_saturation();
        test_reset_in_wait();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
